instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage that sits directly upstream of the `cpu` execute core. Holds a 512-word instruction memory, generates sequential PCs from a loaded start address, and delivers {pc, instruction, opcode} through a valid/ready handshake with a 2-entry buffer so downstream stalls never drop or duplicate words. Supports branch redirect from the core and stops on a HALT opcode.

## Interface

- `PC_W`, 9, PC / memory address width
- `INSTR_W`, 32, instruction width
- `OP_W`, 5, opcode width, taken from `instr[INSTR_W-1 -: OP_W]`
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- `start`  in  1  pulse: load `start_pc`, begin fetching
- `start_pc`  in  PC_W  first fetch address
- `imem_we`  in  1  memory write enable, honoured only in IDLE/HALT
- `imem_waddr`  in  PC_W  write address
- `imem_wdata`  in  INSTR_W  write data
- `redirect_valid`  in  1  core requests fetch from `redirect_pc`
- `redirect_pc`  in  PC_W  redirect target
- `ready_in`  in  1  downstream accepts current output
- `valid_out`  out  1  output word valid
- `pc_out`  out  PC_W  PC of output word
- `instr_out`  out  INSTR_W  instruction word
- `opcode_out`  out  OP_W  top 5 bits of `instr_out`
- `halted`  out  1  high in HALT state

## Operation

- States: IDLE, FETCH, HALT. Reset -> IDLE.
- IDLE: no reads issued; `start` -> FETCH, fetch PC <= `start_pc`.
- FETCH: read issued at fetch PC when `fifo_count + inflight - pop < 2`; fetch PC increments by 1, wraps 511 -> 0.
- Memory read is synchronous, 1-cycle latency; returned word pushed into the 2-entry FIFO with its PC.
- Output = FIFO head; `valid_out` = FIFO non-empty; accept = `valid_out & ready_in` pops head.
- Redirect (FETCH only): FIFO and in-flight read flushed at the same edge; fetch PC <= `redirect_pc`. Redirect wins over accept in the same cycle (head discarded, not counted as delivered).
- HALT: accepting a word with opcode 5'b11111 -> HALT. The HALT word itself is delivered; younger buffered/in-flight words are flushed. In HALT: no reads, redirect ignored, `start` -> FETCH with new `start_pc`.
- `start` in FETCH: treated as redirect to `start_pc`.
- `imem_we` outside IDLE/HALT is ignored.

## Timing

- Reset values: `valid_out`=0, `pc_out`=0, `instr_out`=0, `opcode_out`=0, `halted`=0, FIFO empty, no read in flight, fetch PC=0.
- `reset` mid-operation: all state cleared at that edge regardless of other inputs.
- `start` sampled at edge E0 -> read issued at E1 -> `valid_out`=1 after E2 (2-cycle latency).
- Redirect sampled at edge R0 -> `valid_out`=0 after R0; first target word valid after R0+2.
- With `ready_in` held high, one word per cycle sustained.
- `ready_in` low: output held stable; FIFO fills to 2, reads stop; no word lost or repeated.
- `halted` rises the cycle after the HALT word is accepted.

## Structure

- Shared package `cpu_pkg`: `PC_W`, `INSTR_W`, `OP_W`, `OP_HALT = 5'b11111`, fetch-state enum.
- Sub-module `fetch_fifo`: 2-entry {pc, instr} FIFO with push, pop, flush, count.
- Memory inferred inside `instr_fetch` as synchronous-read array.

## Test plan

- Load words 0x08000001..0x08000004 at 0..3, `start_pc`=0, `ready_in`=1 -> `valid_out` after 2 cycles, pc_out 0,1,2,3 on consecutive cycles with matching instr.
- Same program, `ready_in` low cycles 3-6 -> `pc_out` held at 1, FIFO count 2, resume yields 2,3 with no gap or duplicate.
- `start_pc`=510, words at 510,511,0 -> pc_out 510, 511, 0 (wrap).
- Redirect to 100 while pc_out=2 and `ready_in`=1 -> `valid_out` 0 for 2 cycles, next pc_out=100, words 3/4 never appear.
- Word 0xF8000000 at address 5 -> delivered with opcode 5'h1F, `halted`=1 next cycle, no further `valid_out`; `start` with `start_pc`=0 restarts.
- Assert `reset` while FIFO full -> next cycle all outputs zero, state IDLE, `imem_we` then accepted.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: widths, HALT opcode, fetch FSM states and the buffered word payload.
package cpu_pkg;

  localparam int unsigned PC_W       = 9;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned OP_W       = 5;
  localparam int unsigned IMEM_DEPTH = 1 << PC_W;
  localparam int unsigned CNT_W      = 2;

  localparam logic [OP_W-1:0] OP_HALT = 5'b11111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_word_t;

  function automatic logic [OP_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OP_W];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory write port, core redirect and the output valid/ready stream.
interface instr_fetch_if;
  import cpu_pkg::*;

  logic               imem_we;
  logic [PC_W-1:0]    imem_waddr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               ready_in;
  logic               valid_out;
  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] instr_out;
  logic [OP_W-1:0]    opcode_out;

  modport master (
    input  imem_we, imem_waddr, imem_wdata,
    input  redirect_valid, redirect_pc, ready_in,
    output valid_out, pc_out, instr_out, opcode_out
  );

  modport slave (
    output imem_we, imem_waddr, imem_wdata,
    output redirect_valid, redirect_pc, ready_in,
    input  valid_out, pc_out, instr_out, opcode_out
  );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} buffer; head is always slot 0 so the output comes straight from a register.
module fetch_fifo
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fetch_word_t      push_word,
  input  logic             pop,
  input  logic             flush,
  output fetch_word_t      head,
  output logic [CNT_W-1:0] count
);

  fetch_word_t slot1;
  logic        do_pop;
  logic        do_push;

  assign do_pop  = pop && (count != CNT_W'(0));
  assign do_push = push && ((count != CNT_W'(2)) || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      head  <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == CNT_W'(0)) head <= push_word;
          else                    slot1 <= push_word;
          count <= count + CNT_W'(1);
        end
        2'b01: begin
          head  <= slot1;
          count <= count - CNT_W'(1);
        end
        2'b11: begin
          // Simultaneous push/pop keeps occupancy; the new word lands behind any survivor.
          if (count == CNT_W'(1)) begin
            head <= push_word;
          end else begin
            head  <= slot1;
            slot1 <= push_word;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: 512-word synchronous-read memory, sequential PC generation,
// redirect/HALT handling and a 2-entry output buffer on a valid/ready stream.
module instr_fetch
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  output logic            halted,
  instr_fetch_if.master   bus
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic               inflight_q;
  logic [PC_W-1:0]    rd_pc_q;
  logic [INSTR_W-1:0] rd_data_q;
  logic [INSTR_W-1:0] mem [IMEM_DEPTH];

  logic               rd_en;
  logic               flush;
  logic               pop;
  logic               push;
  logic               accept;
  logic               we_ok;
  logic [2:0]         occ;
  fetch_word_t        head;
  fetch_word_t        push_word;
  logic [CNT_W-1:0]   fifo_count;

  assign accept = bus.valid_out && bus.ready_in;
  // Buffered plus in-flight words after this cycle's pop; a read is only issued when it fits.
  assign occ    = 3'(fifo_count) + 3'(inflight_q) - 3'(accept);
  assign we_ok  = bus.imem_we && (state_q != FETCH);

  // Next-state, fetch-PC and read/flush control.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rd_en      = 1'b0;
    flush      = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d    = FETCH;
          fetch_pc_d = start_pc;
        end
      end
      FETCH: begin
        if (start || bus.redirect_valid) begin
          // Redirect beats accept: the current head is dropped undelivered.
          flush      = 1'b1;
          fetch_pc_d = start ? start_pc : bus.redirect_pc;
        end else if (accept && (opcode_of(head.instr) == OP_HALT)) begin
          pop     = 1'b1;
          flush   = 1'b1;
          state_d = HALT;
        end else begin
          pop = accept;
          if (occ < 3'd2) begin
            rd_en      = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      inflight_q <= 1'b0;
      rd_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= rd_en;
      if (rd_en) rd_pc_q <= fetch_pc_q;
    end
  end

  // Instruction memory: synchronous write, synchronous 1-cycle read.
  always_ff @(posedge clk) begin
    if (we_ok) mem[bus.imem_waddr] <= bus.imem_wdata;
    if (rd_en) rd_data_q <= mem[fetch_pc_q];
  end

  assign push            = inflight_q && !flush;
  assign push_word.pc    = rd_pc_q;
  assign push_word.instr = rd_data_q;

  fetch_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_word (push_word),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (fifo_count)
  );

  assign bus.valid_out  = (fifo_count != CNT_W'(0));
  assign bus.pc_out     = head.pc;
  assign bus.instr_out  = head.instr;
  assign bus.opcode_out = opcode_of(head.instr);
  assign halted         = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: latency, stall, wrap, redirect, write guard, HALT and reset.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [PC_W-1:0] start_pc;
  logic            halted;
  int              errors = 0;
  int              checks = 0;

  instr_fetch_if bus ();

  instr_fetch u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .start_pc (start_pc),
    .halted   (halted),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [INSTR_W-1:0] exp_word(input int p);
    return 32'h0800_0001 + 32'(p);
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; bus.redirect_valid = 1'b0; bus.imem_we = 1'b0; bus.ready_in = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic write_word(input int addr, input logic [INSTR_W-1:0] data);
    bus.imem_we = 1'b1; bus.imem_waddr = PC_W'(addr); bus.imem_wdata = data;
    step();
    bus.imem_we = 1'b0;
  endtask

  task automatic start_fetch(input int pc);
    start = 1'b1; start_pc = PC_W'(pc);
    step();
    start = 1'b0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 512; i++) write_word(i, exp_word(i));
  endtask

  task automatic test_reset();
    checks += 5;
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", bus.valid_out); end
    if (bus.pc_out !== '0) begin errors++; $display("FAIL rst_pc: got %0d want 0", bus.pc_out); end
    if (bus.instr_out !== '0) begin errors++; $display("FAIL rst_instr: got %h want 0", bus.instr_out); end
    if (bus.opcode_out !== '0) begin errors++; $display("FAIL rst_opcode: got %h want 0", bus.opcode_out); end
    if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %0b want 0", halted); end
  endtask

  task automatic test_sequential();
    do_reset();
    bus.ready_in = 1'b1;
    start_fetch(0);
    checks++;
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL seq_lat1: valid got %0b want 0", bus.valid_out); end
    step();
    checks++;
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL seq_lat2: valid got %0b want 0", bus.valid_out); end
    step();
    checks++;
    if (bus.opcode_out !== 5'h01) begin errors++; $display("FAIL seq_opcode: got %h want 01", bus.opcode_out); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.valid_out !== 1'b1 || bus.pc_out !== PC_W'(k) || bus.instr_out !== exp_word(k)) begin
        errors++;
        $display("FAIL seq_word%0d: got v=%0b pc=%0d instr=%h want v=1 pc=%0d instr=%h",
                 k, bus.valid_out, bus.pc_out, bus.instr_out, k, exp_word(k));
      end
      step();
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.ready_in = 1'b1;
    start_fetch(0);
    step(); step();
    checks++;
    if (bus.pc_out !== PC_W'(0)) begin errors++; $display("FAIL stall_pc0: got %0d want 0", bus.pc_out); end
    step();
    bus.ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.valid_out !== 1'b1 || bus.pc_out !== PC_W'(1) || bus.instr_out !== exp_word(1)) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%0b pc=%0d want v=1 pc=1", i, bus.valid_out, bus.pc_out);
      end
      if (i < 4) step();
    end
    checks++;
    if (u_dut.u_fifo.count !== 2'd2) begin errors++; $display("FAIL stall_count: got %0d want 2", u_dut.u_fifo.count); end
    bus.ready_in = 1'b1;
    for (int k = 2; k < 5; k++) begin
      step();
      checks++;
      if (bus.valid_out !== 1'b1 || bus.pc_out !== PC_W'(k) || bus.instr_out !== exp_word(k)) begin
        errors++;
        $display("FAIL stall_resume%0d: got v=%0b pc=%0d want v=1 pc=%0d", k, bus.valid_out, bus.pc_out, k);
      end
    end
  endtask

  task automatic test_wrap();
    logic [PC_W-1:0] p;
    do_reset();
    bus.ready_in = 1'b1;
    start_fetch(510);
    step(); step();
    for (int k = 0; k < 3; k++) begin
      p = PC_W'(510 + k);
      checks++;
      if (bus.valid_out !== 1'b1 || bus.pc_out !== p || bus.instr_out !== exp_word(int'(p))) begin
        errors++;
        $display("FAIL wrap%0d: got v=%0b pc=%0d instr=%h want pc=%0d instr=%h",
                 k, bus.valid_out, bus.pc_out, bus.instr_out, p, exp_word(int'(p)));
      end
      step();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.ready_in = 1'b1;
    start_fetch(0);
    step(); step(); step(); step();
    checks++;
    if (bus.pc_out !== PC_W'(2)) begin errors++; $display("FAIL redir_pre: got pc=%0d want 2", bus.pc_out); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = PC_W'(100);
    step();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL redir_gap1: valid got %0b want 0", bus.valid_out); end
    step();
    checks++;
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL redir_gap2: valid got %0b want 0", bus.valid_out); end
    for (int k = 100; k < 102; k++) begin
      step();
      checks++;
      if (bus.valid_out !== 1'b1 || bus.pc_out !== PC_W'(k) || bus.instr_out !== exp_word(k)) begin
        errors++;
        $display("FAIL redir_tgt%0d: got v=%0b pc=%0d want v=1 pc=%0d", k, bus.valid_out, bus.pc_out, k);
      end
    end
  endtask

  task automatic test_imem_guard();
    do_reset();
    bus.ready_in = 1'b1;
    start_fetch(0);
    write_word(30, 32'hDEAD_BEEF);
    repeat (31) step();
    checks++;
    if (bus.pc_out !== PC_W'(30) || bus.instr_out !== exp_word(30)) begin
      errors++;
      $display("FAIL we_guard: got pc=%0d instr=%h want pc=30 instr=%h", bus.pc_out, bus.instr_out, exp_word(30));
    end
  endtask

  task automatic test_halt();
    do_reset();
    write_word(5, 32'hF800_0000);
    bus.ready_in = 1'b1;
    start_fetch(0);
    repeat (7) step();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.pc_out !== PC_W'(5) || bus.instr_out !== 32'hF800_0000 ||
        bus.opcode_out !== 5'h1F || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_word: got v=%0b pc=%0d instr=%h op=%h h=%0b want v=1 pc=5 instr=f8000000 op=1f h=0",
               bus.valid_out, bus.pc_out, bus.instr_out, bus.opcode_out, halted);
    end
    step();
    checks++;
    if (halted !== 1'b1 || bus.valid_out !== 1'b0) begin
      errors++; $display("FAIL halt_enter: got h=%0b v=%0b want h=1 v=0", halted, bus.valid_out);
    end
    bus.redirect_valid = 1'b1; bus.redirect_pc = PC_W'(50);
    step();
    bus.redirect_valid = 1'b0;
    step();
    checks++;
    if (halted !== 1'b1 || bus.valid_out !== 1'b0) begin
      errors++; $display("FAIL halt_redir_ignored: got h=%0b v=%0b want h=1 v=0", halted, bus.valid_out);
    end
    start_fetch(0);
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL halt_restart: halted got %0b want 0", halted); end
    step(); step();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.pc_out !== PC_W'(0) || bus.instr_out !== exp_word(0)) begin
      errors++; $display("FAIL halt_restart_word: got v=%0b pc=%0d want v=1 pc=0", bus.valid_out, bus.pc_out);
    end
    do_reset();
    write_word(5, exp_word(5));
  endtask

  task automatic test_reset_full();
    do_reset();
    bus.ready_in = 1'b0;
    start_fetch(0);
    repeat (5) step();
    checks++;
    if (u_dut.u_fifo.count !== 2'd2 || bus.pc_out !== PC_W'(0)) begin
      errors++; $display("FAIL rfull_pre: got count=%0d pc=%0d want count=2 pc=0", u_dut.u_fifo.count, bus.pc_out);
    end
    reset = 1'b1; start = 1'b1; start_pc = PC_W'(9); bus.redirect_valid = 1'b1; bus.ready_in = 1'b1;
    step();
    reset = 1'b0; start = 1'b0; bus.redirect_valid = 1'b0;
    test_reset();
    checks++;
    if (u_dut.state_q !== IDLE) begin errors++; $display("FAIL rfull_state: got %0d want IDLE", u_dut.state_q); end
    write_word(7, 32'h1234_5678);
    start_fetch(7);
    step(); step();
    checks++;
    if (bus.pc_out !== PC_W'(7) || bus.instr_out !== 32'h1234_5678) begin
      errors++; $display("FAIL rfull_write: got pc=%0d instr=%h want pc=7 instr=12345678", bus.pc_out, bus.instr_out);
    end
    do_reset();
    write_word(7, exp_word(7));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_pc = '0;
    bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.ready_in = 1'b0;
    step(); step();
    reset = 1'b0;
    test_reset();
    fill_mem();
    test_sequential();
    test_stall();
    test_wrap();
    test_redirect();
    test_imem_guard();
    test_halt();
    test_reset_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
